brisc_rob: RTL and testbench
============================

Name: brisc_rob

Overview:
- Reorder buffer and the receiving end of the rob_req_t completion interface.
- Decode allocates tickets in program order. Execution/memory/multiply pipes post completions out of order as rob_req_t.
- The ROB retires in order to the register file and store buffer.
- It also raises precise exceptions at the head and flushes itself.

Parameters:
- NUM_ENTRIES, NUM_ROB_ENTRIES (16): entry count; must be a power of two.
- NUM_WR_PORTS, 2: completion ports (port 0 ALU/memory, port 1 multiplier).
- TKT_BITS, $clog2(NUM_ENTRIES): ticket width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush_i  in  1  external flush; empties ROB
- alloc_valid_i  in  1  decode requests an entry
- alloc_ready_o  out  1  entry available
- alloc_ticket_o  out  TKT_BITS  ticket granted (tail index)
- wr_req_i  in  NUM_WR_PORTS x rob_req_t  completions; .req qualifies
- commit_valid_o  out  1  head complete, no exception
- commit_ready_i  in  1  consumer accepts commit
- commit_we_o  out  1  register write (not store, dest != 0)
- commit_store_o  out  1  committed entry is a store (store buffer drain)
- commit_dest_o  out  REG_BITS  destination register
- commit_result_o  out  XLEN  result
- commit_ticket_o  out  TKT_BITS  head ticket
- xcpt_valid_o  out  1  head completed with xcpt != NO_XCPT
- xcpt_cause_o  out  2 (xcpt_e)  exception cause
- xcpt_ticket_o  out  TKT_BITS  faulting ticket
- empty_o  out  1  no entries allocated
- count_o  out  TKT_BITS+1  occupancy

Behaviour:
- Storage:
  - Per entry: valid, done, xcpt, result, dest, store.
  - head/tail pointers are TKT_BITS+1 wide with a wrap bit.
  - full = index bits equal and wrap bits differ; empty = pointers equal.
- Reset (async): head=tail=0, all valid/done=0. Outputs: alloc_ready_o=1, alloc_ticket_o=0, empty_o=1, count_o=0, all commit_*/xcpt_* =0.
- Allocation:
  - alloc_ready_o = !full && !flush_i.
  - On alloc_valid_i && alloc_ready_o at the edge: entry[tail] valid=1, done=0, tail++.
  - alloc_ticket_o = tail[TKT_BITS-1:0], combinational.
  - A slot freed by a same-cycle commit is not reusable that cycle; full blocks allocation.
- Completion:
  - wr_req_i[p].req with ticket t writes xcpt/result/dest/store and sets done, at the edge.
  - Writes to an invalid entry are ignored.
  - Two ports hitting the same ticket in one cycle: lower port index wins.
- Commit:
  - Decided from registered head state only; a completion becomes committable the cycle after it is written (minimum alloc→commit latency 2 cycles).
  - commit_valid_o = head valid && done && xcpt==NO_XCPT.
  - On commit_valid_o && commit_ready_i: entry cleared, head++.
  - commit_we_o = commit_valid_o && !store && dest!=0.
  - commit_store_o = commit_valid_o && store.
  - Data outputs reflect the head entry whenever it is valid; 0 otherwise.
- Exception:
  - Head valid && done && xcpt!=NO_XCPT → xcpt_valid_o=1 (combinational), with cause and ticket; commit_valid_o=0.
  - Independent of commit_ready_i.
  - At that edge the whole ROB flushes (head=tail=0, all valid=0), so xcpt_valid_o is a single-cycle pulse.
  - Allocation in that cycle is dropped.
- flush_i: at the edge, same clearing as exception. Overrides allocation, completion and commit in that cycle.
- Wrap-around: pointers increment modulo 2*NUM_ENTRIES; ticket index wraps 15→0.
- count_o = tail - head (TKT_BITS+1 bits, range 0..NUM_ENTRIES).

Optional Feature:
- BRISC_ROB_BYPASS_EN defined: adds ports per operand r∈{0,1}:
  - byp_ticket_i[r] TKT_BITS in
  - byp_hit_o[r] 1 out
  - byp_data_o[r] XLEN out
- byp_hit_o = entry valid && done && xcpt==NO_XCPT && !store; byp_data_o = result when hit, else 0. Pure combinational read.
- Undefined: ports absent; no read muxes synthesized.

Decomposition:
- Shared package:
  - rob_req_t and xcpt_e (already present).
  - NUM_ROB_ENTRIES.
  - New rob_entry_t {valid, done, xcpt, result, dest, store}.
  - rob_commit_t bundling the commit outputs, for the store buffer/regfile consumers.
- Optional sub-module brisc_rob_ptr: wrap-bit pointer with inc/clear, instanced for head and tail.

Test Plan:
- Reset then allocate 16 → tickets 0..15; alloc_ready_o=0, count_o=16; 17th request not granted.
- Allocate t0,t1; complete t1 (result 0x55, dest 5), then t0 (0xAA, dest 3) → commits in order: dest 3/0xAA, then dest 5/0x55; commit_we_o=1 both.
- Complete head with xcpt=MEM_UNALIGNED, 3 entries allocated → xcpt_valid_o=1 for one cycle, cause=01, ticket=head; next cycle empty_o=1, count_o=0.
- commit_ready_i=0 for 4 cycles with head done → commit_valid_o held, head unchanged; store entry gives commit_store_o=1, commit_we_o=0; dest=0 gives commit_we_o=0.
- Ports 0 and 1 complete ticket 2 simultaneously (0x11 vs 0x22) → committed result 0x11; completion to unallocated ticket 9 → no state change.
- Wrap: 40 alloc/commit pairs → ticket 15 followed by 0, count_o never exceeds 16; reset asserted mid-stream → all outputs at reset values immediately.

Source files
------------

// File: rtl/brisc_rob_pkg.sv
// ---------------------------------------------------------------------------
// brisc_rob_pkg
// Shared types and constants for the reorder buffer and its clients:
//   - xcpt_e       : exception cause carried by a completion
//   - rob_req_t    : completion request posted by ALU/memory/multiply pipes
//   - rob_entry_t  : one reorder buffer slot
//   - rob_commit_t : commit bundle consumed by the register file / store buffer
// ---------------------------------------------------------------------------
package brisc_rob_pkg;

   localparam int XLEN              = 32;
   localparam int REG_BITS          = 5;
   localparam int NUM_ROB_ENTRIES   = 16;
   localparam int ROB_TKT_BITS      = $clog2(NUM_ROB_ENTRIES);
   localparam int NUM_ROB_WR_PORTS  = 2;

   typedef enum logic [1:0] {
      NO_XCPT       = 2'b00,
      MEM_UNALIGNED = 2'b01,
      MEM_FAULT     = 2'b10,
      ILLEGAL_INSN  = 2'b11
   } xcpt_e;

   typedef struct packed {
      logic                    req;
      logic [ROB_TKT_BITS-1:0] ticket;
      xcpt_e                   xcpt;
      logic [XLEN-1:0]         result;
      logic [REG_BITS-1:0]     dest;
      logic                    store;
   } rob_req_t;

   typedef struct packed {
      logic                valid;
      logic                done;
      xcpt_e               xcpt;
      logic [XLEN-1:0]     result;
      logic [REG_BITS-1:0] dest;
      logic                store;
   } rob_entry_t;

   typedef struct packed {
      logic                    valid;
      logic                    we;
      logic                    store;
      logic [REG_BITS-1:0]     dest;
      logic [XLEN-1:0]         result;
      logic [ROB_TKT_BITS-1:0] ticket;
   } rob_commit_t;

   // Entry is ready to leave the head: allocated and its result written back.
   function automatic logic entry_ready(input rob_entry_t e);
      return e.valid && e.done;
   endfunction

endpackage

// File: rtl/brisc_rob_ptr.sv
// ---------------------------------------------------------------------------
// brisc_rob_ptr
// Circular buffer pointer with an extra wrap bit (MSB). The wrap bit lets the
// owner tell a full buffer from an empty one when the index bits match.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   clear_i    : synchronous clear to 0 (flush / exception)
//   inc_i      : advance by one, modulo 2**W
//   ptr_o      : registered pointer value
// ---------------------------------------------------------------------------
module brisc_rob_ptr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   // Pointer register: clear has priority over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_o <= '0;
      end else if (clear_i) begin
         ptr_o <= '0;
      end else if (inc_i) begin
         ptr_o <= ptr_o + W'(1);
      end else begin
         ptr_o <= ptr_o;
      end
   end

endmodule

// File: rtl/brisc_rob.sv
// ---------------------------------------------------------------------------
// brisc_rob
// Reorder buffer. Decode allocates tickets in program order, completion pipes
// post results out of order, the head retires in order to the register file
// and store buffer. A completed head carrying an exception raises a one-cycle
// precise exception pulse and empties the whole buffer.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   flush_i           : external flush, empties the buffer at the edge
//   alloc_valid_i     : decode requests an entry
//   alloc_ready_o     : an entry can be granted this cycle
//   alloc_ticket_o    : ticket granted (tail index)
//   wr_req_i          : completion ports (0: ALU/memory, 1: multiplier)
//   commit_*          : head retirement handshake and data
//   xcpt_*            : precise exception at the head
//   empty_o, count_o  : occupancy
// Optional build macro BRISC_ROB_BYPASS_EN adds two operand bypass read ports
// (byp_ticket_i / byp_hit_o / byp_data_o).
// ---------------------------------------------------------------------------
module brisc_rob
   import brisc_rob_pkg::*;
#(
   parameter int NUM_ENTRIES  = NUM_ROB_ENTRIES,
   parameter int NUM_WR_PORTS = NUM_ROB_WR_PORTS,
   parameter int TKT_BITS     = $clog2(NUM_ENTRIES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_i,
   input  logic                alloc_valid_i,
   output logic                alloc_ready_o,
   output logic [TKT_BITS-1:0] alloc_ticket_o,
   input  rob_req_t            wr_req_i [NUM_WR_PORTS],
   output logic                commit_valid_o,
   input  logic                commit_ready_i,
   output logic                commit_we_o,
   output logic                commit_store_o,
   output logic [REG_BITS-1:0] commit_dest_o,
   output logic [XLEN-1:0]     commit_result_o,
   output logic [TKT_BITS-1:0] commit_ticket_o,
   output logic                xcpt_valid_o,
   output xcpt_e               xcpt_cause_o,
   output logic [TKT_BITS-1:0] xcpt_ticket_o,
   output logic                empty_o,
   output logic [TKT_BITS:0]   count_o
`ifdef BRISC_ROB_BYPASS_EN
   ,
   input  logic [TKT_BITS-1:0] byp_ticket_i [2],
   output logic                byp_hit_o    [2],
   output logic [XLEN-1:0]     byp_data_o   [2]
`endif
);

   rob_entry_t          entry_r     [NUM_ENTRIES];
   rob_entry_t          entry_nxt_s [NUM_ENTRIES];
   logic [TKT_BITS:0]   head_ptr_s;
   logic [TKT_BITS:0]   tail_ptr_s;
   logic [TKT_BITS-1:0] head_idx_s;
   logic [TKT_BITS-1:0] tail_idx_s;
   rob_entry_t          head_e_s;
   logic                full_s;
   logic                head_ok_s;
   logic                clear_s;
   logic                alloc_fire_s;
   logic                commit_fire_s;
   rob_req_t            comp_req_s;
   logic                comp_hit_s;
   logic                comp_match_s;
   rob_commit_t         commit_s;

   assign head_idx_s = head_ptr_s[TKT_BITS-1:0];
   assign tail_idx_s = tail_ptr_s[TKT_BITS-1:0];
   assign head_e_s   = entry_r[head_idx_s];

   assign full_s  = (head_idx_s == tail_idx_s) && (head_ptr_s[TKT_BITS] != tail_ptr_s[TKT_BITS]);
   assign empty_o = (head_ptr_s == tail_ptr_s);
   assign count_o = tail_ptr_s - head_ptr_s;

   // Commit and exception are decided from registered head state only.
   assign head_ok_s      = entry_ready(head_e_s);
   assign xcpt_valid_o   = head_ok_s && (head_e_s.xcpt != NO_XCPT);
   assign commit_valid_o = head_ok_s && (head_e_s.xcpt == NO_XCPT);

   assign clear_s       = flush_i || xcpt_valid_o;
   assign alloc_ready_o = !full_s && !flush_i;
   // An exception at the head wipes the buffer, so a same-cycle grant is dropped.
   assign alloc_fire_s  = alloc_valid_i && alloc_ready_o && !xcpt_valid_o;
   assign commit_fire_s = commit_valid_o && commit_ready_i && !flush_i;

   assign alloc_ticket_o = tail_idx_s;

   // Commit bundle: data fields follow the head whenever it holds an entry.
   always_comb begin
      commit_s        = '0;
      commit_s.valid  = commit_valid_o;
      commit_s.we     = commit_valid_o && !head_e_s.store && (head_e_s.dest != REG_BITS'(0));
      commit_s.store  = commit_valid_o && head_e_s.store;
      if (head_e_s.valid) begin
         commit_s.dest   = head_e_s.dest;
         commit_s.result = head_e_s.result;
         commit_s.ticket = ROB_TKT_BITS'(head_idx_s);
      end else begin
         commit_s.dest   = '0;
         commit_s.result = '0;
         commit_s.ticket = '0;
      end
   end

   assign commit_we_o     = commit_s.we;
   assign commit_store_o  = commit_s.store;
   assign commit_dest_o   = commit_s.dest;
   assign commit_result_o = commit_s.result;
   assign commit_ticket_o = TKT_BITS'(commit_s.ticket);

   assign xcpt_cause_o  = xcpt_valid_o ? head_e_s.xcpt : NO_XCPT;
   assign xcpt_ticket_o = xcpt_valid_o ? head_idx_s : '0;

   // Next entry state: clear > commit > allocate > completion > hold.
   // Ports are scanned high-to-low so the lowest port index wins a collision.
   always_comb begin
      comp_req_s   = '0;
      comp_hit_s   = 1'b0;
      comp_match_s = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         entry_nxt_s[i] = entry_r[i];
         comp_req_s     = '0;
         comp_hit_s     = 1'b0;
         for (int p = NUM_WR_PORTS - 1; p >= 0; p--) begin
            comp_match_s = wr_req_i[p].req && (TKT_BITS'(wr_req_i[p].ticket) == TKT_BITS'(i));
            comp_req_s   = comp_match_s ? wr_req_i[p] : comp_req_s;
            comp_hit_s   = comp_hit_s | comp_match_s;
         end
         if (clear_s) begin
            entry_nxt_s[i] = '0;
         end else if (commit_fire_s && (head_idx_s == TKT_BITS'(i))) begin
            entry_nxt_s[i] = '0;
         end else if (alloc_fire_s && (tail_idx_s == TKT_BITS'(i))) begin
            entry_nxt_s[i]       = '0;
            entry_nxt_s[i].valid = 1'b1;
         end else if (comp_hit_s && entry_r[i].valid) begin
            entry_nxt_s[i].done   = 1'b1;
            entry_nxt_s[i].xcpt   = comp_req_s.xcpt;
            entry_nxt_s[i].result = comp_req_s.result;
            entry_nxt_s[i].dest   = comp_req_s.dest;
            entry_nxt_s[i].store  = comp_req_s.store;
         end else begin
            entry_nxt_s[i] = entry_r[i];
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_r[i] <= entry_nxt_s[i];
         end
      end
   end

   brisc_rob_ptr #(.W(TKT_BITS + 1)) u_head_ptr (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_s),
      .inc_i   (commit_fire_s),
      .ptr_o   (head_ptr_s)
   );

   brisc_rob_ptr #(.W(TKT_BITS + 1)) u_tail_ptr (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_s),
      .inc_i   (alloc_fire_s),
      .ptr_o   (tail_ptr_s)
   );

`ifdef BRISC_ROB_BYPASS_EN
   rob_entry_t byp_e_s [2];

   // Operand bypass: forward finished, non-faulting, non-store results.
   always_comb begin
      for (int r = 0; r < 2; r++) begin
         byp_e_s[r]   = entry_r[byp_ticket_i[r]];
         byp_hit_o[r] = entry_ready(byp_e_s[r]) && (byp_e_s[r].xcpt == NO_XCPT) && !byp_e_s[r].store;
         if (byp_hit_o[r]) begin
            byp_data_o[r] = byp_e_s[r].result;
         end else begin
            byp_data_o[r] = '0;
         end
      end
   end
`else
   // No bypass read path in this build.
`endif

endmodule

// File: tb/tb_brisc_rob.sv
// ---------------------------------------------------------------------------
// tb_brisc_rob
// Directed bench for brisc_rob. A queue-based model of program order tracks
// which tickets are live; a negedge compare process checks every output each
// cycle against it, and the directed sequences add hand-computed literals.
// ---------------------------------------------------------------------------
module tb_brisc_rob;
   import brisc_rob_pkg::*;

   localparam int N  = 16;
   localparam int NP = 2;
   localparam int TB = 4;

   logic            clk;
   logic            reset;
   logic            flush_i;
   logic            alloc_valid_i;
   logic            alloc_ready_o;
   logic [TB-1:0]   alloc_ticket_o;
   rob_req_t        wr_req [NP];
   logic            commit_valid_o;
   logic            commit_ready_i;
   logic            commit_we_o;
   logic            commit_store_o;
   logic [REG_BITS-1:0] commit_dest_o;
   logic [XLEN-1:0] commit_result_o;
   logic [TB-1:0]   commit_ticket_o;
   logic            xcpt_valid_o;
   xcpt_e           xcpt_cause_o;
   logic [TB-1:0]   xcpt_ticket_o;
   logic            empty_o;
   logic [TB:0]     count_o;

   int n_assert = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   brisc_rob dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_ticket_o(alloc_ticket_o),
      .wr_req_i(wr_req),
      .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
      .commit_we_o(commit_we_o), .commit_store_o(commit_store_o),
      .commit_dest_o(commit_dest_o), .commit_result_o(commit_result_o),
      .commit_ticket_o(commit_ticket_o),
      .xcpt_valid_o(xcpt_valid_o), .xcpt_cause_o(xcpt_cause_o), .xcpt_ticket_o(xcpt_ticket_o),
      .empty_o(empty_o), .count_o(count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_q[$];     // live tickets, oldest first
   int          m_nt;       // next ticket to grant
   bit          m_done [N];
   logic [1:0]  m_xc   [N];
   logic [31:0] m_res  [N];
   logic [4:0]  m_dst  [N];
   bit          m_st   [N];
   int          ms_sz, ms_h, ms_t;
   bit          ms_ex, ms_cm;

   function automatic bit in_q(input int t);
      foreach (m_q[k]) if (m_q[k] == t) return 1'b1;
      return 1'b0;
   endfunction

   // Model update on each edge using the inputs present at that edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_nt = 0;
      end else begin
         ms_sz = m_q.size();
         ms_h  = (ms_sz > 0) ? m_q[0] : 0;
         ms_ex = (ms_sz > 0) && m_done[ms_h] && (m_xc[ms_h] != 2'd0);
         ms_cm = (ms_sz > 0) && m_done[ms_h] && (m_xc[ms_h] == 2'd0) && commit_ready_i;
         if (flush_i || ms_ex) begin
            m_q.delete();
            m_nt = 0;
         end else begin
            for (int p = NP - 1; p >= 0; p--) begin
               ms_t = int'(wr_req[p].ticket);
               if (wr_req[p].req && in_q(ms_t)) begin
                  m_done[ms_t] = 1'b1;
                  m_xc[ms_t]   = wr_req[p].xcpt;
                  m_res[ms_t]  = wr_req[p].result;
                  m_dst[ms_t]  = wr_req[p].dest;
                  m_st[ms_t]   = wr_req[p].store;
               end
            end
            if (ms_cm) void'(m_q.pop_front());
            if (alloc_valid_i && ms_sz < N) begin
               m_q.push_back(m_nt);
               m_done[m_nt] = 1'b0; m_xc[m_nt] = 2'd0; m_res[m_nt] = 32'd0;
               m_dst[m_nt] = 5'd0;  m_st[m_nt] = 1'b0;
               m_nt = (m_nt + 1) % N;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      int sz, h;
      bit hv, cv, xv;
      if (cmp_en) begin
         sz = m_q.size();
         hv = (sz > 0);
         h  = hv ? m_q[0] : 0;
         cv = hv && m_done[h] && (m_xc[h] == 2'd0);
         xv = hv && m_done[h] && (m_xc[h] != 2'd0);
         chk("m_alloc_ready", alloc_ready_o, (sz < N) && !flush_i);
         chk("m_alloc_ticket", alloc_ticket_o, m_nt);
         chk("m_commit_valid", commit_valid_o, cv);
         chk("m_commit_we", commit_we_o, cv && !m_st[h] && (m_dst[h] != 5'd0));
         chk("m_commit_store", commit_store_o, cv && m_st[h]);
         chk("m_commit_dest", commit_dest_o, hv ? m_dst[h] : 5'd0);
         chk("m_commit_result", commit_result_o, hv ? m_res[h] : 32'd0);
         chk("m_commit_ticket", commit_ticket_o, hv ? h : 0);
         chk("m_xcpt_valid", xcpt_valid_o, xv);
         chk("m_xcpt_cause", xcpt_cause_o, xv ? m_xc[h] : 2'd0);
         chk("m_xcpt_ticket", xcpt_ticket_o, xv ? h : 0);
         chk("m_empty", empty_o, sz == 0);
         chk("m_count", count_o, sz);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clr_in();
      alloc_valid_i = 1'b0;
      flush_i       = 1'b0;
      for (int p = 0; p < NP; p++) wr_req[p] = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr_in();
      #1;
   endtask

   task automatic comp(input int p, input int t, input logic [1:0] x,
                       input logic [31:0] r, input logic [4:0] d, input bit s);
      wr_req[p].req    = 1'b1;
      wr_req[p].ticket = t[TB-1:0];
      wr_req[p].xcpt   = xcpt_e'(x);
      wr_req[p].result = r;
      wr_req[p].dest   = d;
      wr_req[p].store  = s;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, alloc_ready_o, 1'b1);
      chk({tag, "_ticket"}, alloc_ticket_o, 4'd0);
      chk({tag, "_empty"}, empty_o, 1'b1);
      chk({tag, "_count"}, count_o, 5'd0);
      chk({tag, "_cvalid"}, commit_valid_o, 1'b0);
      chk({tag, "_we"}, commit_we_o, 1'b0);
      chk({tag, "_result"}, commit_result_o, 32'd0);
      chk({tag, "_xvalid"}, xcpt_valid_o, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      commit_ready_i = 1'b0;
      clr_in();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      cmp_en = 1'b1;
      chk_reset_vals("rst");

      // Fill all 16 entries, then try a 17th.
      for (int i = 0; i < N; i++) begin
         alloc_valid_i = 1'b1;
         #1 chk("fill_ticket", alloc_ticket_o, i);
         step();
      end
      chk("full_ready", alloc_ready_o, 1'b0);
      chk("full_count", count_o, 5'd16);
      alloc_valid_i = 1'b1;
      step();
      chk("full_17th_count", count_o, 5'd16);
      flush_i = 1'b1;
      step();
      chk("flush_empty", empty_o, 1'b1);
      chk("flush_count", count_o, 5'd0);

      // Out-of-order completion, in-order commit.
      commit_ready_i = 1'b1;
      alloc_valid_i = 1'b1; step();
      alloc_valid_i = 1'b1; step();
      chk("ooo_count", count_o, 5'd2);
      comp(0, 1, 2'd0, 32'h55, 5'd5, 1'b0); step();
      chk("ooo_t0_not_ready", commit_valid_o, 1'b0);
      comp(0, 0, 2'd0, 32'hAA, 5'd3, 1'b0); step();
      chk("ooo_c0_valid", commit_valid_o, 1'b1);
      chk("ooo_c0_dest", commit_dest_o, 5'd3);
      chk("ooo_c0_result", commit_result_o, 32'hAA);
      chk("ooo_c0_we", commit_we_o, 1'b1);
      step();
      chk("ooo_c1_dest", commit_dest_o, 5'd5);
      chk("ooo_c1_result", commit_result_o, 32'h55);
      chk("ooo_c1_we", commit_we_o, 1'b1);
      chk("ooo_c1_ticket", commit_ticket_o, 4'd1);
      step();
      chk("ooo_empty", empty_o, 1'b1);

      // Exception at head with 3 entries (tickets 2,3,4).
      repeat (3) begin alloc_valid_i = 1'b1; step(); end
      comp(0, 2, 2'd1, 32'h0, 5'd1, 1'b0); step();
      chk("xc_valid", xcpt_valid_o, 1'b1);
      chk("xc_cause", xcpt_cause_o, 2'b01);
      chk("xc_ticket", xcpt_ticket_o, 4'd2);
      chk("xc_no_commit", commit_valid_o, 1'b0);
      alloc_valid_i = 1'b1;
      step();
      chk("xc_pulse_done", xcpt_valid_o, 1'b0);
      chk("xc_empty", empty_o, 1'b1);
      chk("xc_count", count_o, 5'd0);
      chk("xc_alloc_dropped", alloc_ticket_o, 4'd0);

      // Backpressure, store and dest-0 commits.
      commit_ready_i = 1'b0;
      repeat (3) begin alloc_valid_i = 1'b1; step(); end
      comp(0, 0, 2'd0, 32'h33, 5'd7, 1'b0);
      comp(1, 1, 2'd0, 32'h44, 5'd9, 1'b1);
      step();
      comp(0, 2, 2'd0, 32'h66, 5'd0, 1'b0); step();
      repeat (4) begin
         chk("bp_valid", commit_valid_o, 1'b1);
         chk("bp_ticket", commit_ticket_o, 4'd0);
         chk("bp_count", count_o, 5'd3);
         step();
      end
      commit_ready_i = 1'b1;
      #1 chk("bp_we", commit_we_o, 1'b1);
      step();
      chk("st_store", commit_store_o, 1'b1);
      chk("st_we", commit_we_o, 1'b0);
      chk("st_result", commit_result_o, 32'h44);
      step();
      chk("d0_valid", commit_valid_o, 1'b1);
      chk("d0_we", commit_we_o, 1'b0);
      chk("d0_store", commit_store_o, 1'b0);
      step();
      chk("bp_empty", empty_o, 1'b1);

      // Port collision and write to an unallocated ticket.
      flush_i = 1'b1; step();
      commit_ready_i = 1'b0;
      repeat (3) begin alloc_valid_i = 1'b1; step(); end
      comp(0, 2, 2'd0, 32'h11, 5'd4, 1'b0);
      comp(1, 2, 2'd0, 32'h22, 5'd6, 1'b0);
      step();
      comp(0, 9, 2'd0, 32'h99, 5'd8, 1'b0); step();
      chk("unalloc_count", count_o, 5'd3);
      chk("unalloc_ticket", alloc_ticket_o, 4'd3);
      comp(0, 0, 2'd0, 32'h1, 5'd1, 1'b0);
      comp(1, 1, 2'd0, 32'h2, 5'd2, 1'b0);
      step();
      commit_ready_i = 1'b1;
      step();
      step();
      chk("coll_result", commit_result_o, 32'h11);
      chk("coll_dest", commit_dest_o, 5'd4);
      step();
      chk("coll_empty", empty_o, 1'b1);

      // Wrap-around over 40 alloc/commit pairs.
      flush_i = 1'b1; step();
      for (int i = 0; i < 40; i++) begin
         alloc_valid_i = 1'b1;
         #1 chk("wrap_ticket", alloc_ticket_o, i % N);
         step();
         comp(0, i % N, 2'd0, 32'(i + 100), 5'((i % 31) + 1), 1'b0);
         step();
         chk("wrap_commit_ticket", commit_ticket_o, i % N);
         step();
      end

      // Reset asserted mid-stream.
      commit_ready_i = 1'b0;
      alloc_valid_i = 1'b1; step();
      alloc_valid_i = 1'b1; step();
      comp(0, 8, 2'd0, 32'h7, 5'd2, 1'b0); step();
      reset = 1'b1;
      #1 chk_reset_vals("midrst");
      step();
      reset = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
